// File: rtl/fpnew_pkg.sv
// ============================================================================
// Module : fpnew_pkg
// Brief  : Shared types and helpers for the FPU operation-group dispatch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fpnew_pkg;

    typedef enum logic {
        DISPATCH_INORDER   = 1'b0,
        DISPATCH_UNORDERED = 1'b1
    } dispatch_mode_e;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpnew_lane_id_fifo.sv
// ============================================================================
// Module : fpnew_lane_id_fifo
// Brief  : Lane-ID FIFO recording dispatch order for in-order retirement.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fpnew_lane_id_fifo
    import fpnew_pkg::*;
#(
    parameter int unsigned  DEPTH = 8,
    parameter int unsigned  WIDTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy, not pointer equality, decides full/empty.
    assign w_do_push = push_i & (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = pop_i & (r_count != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_i;
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/fpnew_opgroup_lane_dispatch.sv
// ============================================================================
// Module : fpnew_opgroup_lane_dispatch
// Brief  : Round-robin dispatch of ops to replicated lanes and result retire.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fpnew_opgroup_lane_dispatch
    import fpnew_pkg::*;
#(
    parameter int unsigned    NumLanes    = 4,
    parameter int unsigned    MaxInflight = 8,
    parameter dispatch_mode_e Mode        = fpnew_pkg::DISPATCH_INORDER,
    parameter type            InType      = logic,
    parameter type            OutType     = logic,
    localparam int unsigned   LANE_W      = idx_width(NumLanes)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  InType                       in_data_i,
    output logic [NumLanes-1:0]         lane_valid_o,
    input  logic [NumLanes-1:0]         lane_ready_i,
    output InType                       lane_data_o,
    input  logic [NumLanes-1:0]         lane_out_valid_i,
    output logic [NumLanes-1:0]         lane_out_ready_o,
    input  OutType [NumLanes-1:0]       lane_out_data_i,
    input  logic [NumLanes-1:0]         lane_busy_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output OutType                      out_data_o,
    output logic [LANE_W-1:0]           out_lane_o,
    output logic                        busy_o
);

    localparam int unsigned CNT_W = $clog2(MaxInflight + 1);

    logic [CNT_W-1:0]    r_count;
    logic [LANE_W-1:0]   r_disp_ptr;
    logic [LANE_W-1:0]   w_disp_sel;
    logic                w_full;
    logic                w_accept;
    logic                w_out_hs;
    logic                w_ret_valid;
    logic [LANE_W-1:0]   w_ret_lane;
    logic [NumLanes-1:0] w_lane_out_ready;

    // First requesting lane at or after ptr, wrapping; returns ptr if none.
    function automatic logic [LANE_W-1:0] rr_pick(input logic [NumLanes-1:0] req,
                                                  input logic [LANE_W-1:0]   ptr);
        logic [LANE_W-1:0] pick;
        logic              found;
        int unsigned       idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NumLanes; i++) begin
            idx = (32'(ptr) + i) % NumLanes;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = LANE_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] l);
        return (l == LANE_W'(NumLanes - 1)) ? '0 : l + LANE_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Dispatch
    // ------------------------------------------------------------------
    assign w_disp_sel = rr_pick(lane_ready_i, r_disp_ptr);
    assign w_full     = (r_count == CNT_W'(MaxInflight));
    // Full blocks accept even on a same-cycle pop: no out_ready_i -> in_ready_o path.
    assign in_ready_o = (|lane_ready_i) & ~w_full & ~flush_i;
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_out_hs   = w_ret_valid & out_ready_i & ~flush_i;

    always_comb begin
        lane_valid_o = '0;
        if (w_accept) lane_valid_o[w_disp_sel] = 1'b1;
    end

    assign lane_data_o = in_data_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_count    <= '0;
            r_disp_ptr <= '0;
        end else begin
            if (w_accept) r_disp_ptr <= next_lane(w_disp_sel);
            case ({w_accept, w_out_hs})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Retire
    // ------------------------------------------------------------------
    if (Mode == DISPATCH_INORDER) begin : g_inorder
        logic [LANE_W-1:0] w_head;
        logic [CNT_W-1:0]  w_fifo_count;
        logic              w_empty;

        fpnew_lane_id_fifo #(
            .DEPTH (MaxInflight),
            .WIDTH (LANE_W)
        ) u_id_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (w_accept),
            .data_i  (w_disp_sel),
            .pop_i   (w_out_hs),
            .data_o  (w_head),
            .count_o (w_fifo_count)
        );

        assign w_empty     = (w_fifo_count == '0);
        assign w_ret_lane  = w_head;
        assign w_ret_valid = ~w_empty & lane_out_valid_i[w_head];

        // Non-head lanes keep their results until they reach the head.
        always_comb begin
            w_lane_out_ready         = '0;
            w_lane_out_ready[w_head] = ~w_empty & out_ready_i & ~flush_i;
        end
    end else begin : g_unordered
        logic              r_lock;
        logic [LANE_W-1:0] r_lock_lane;
        logic [LANE_W-1:0] r_ret_ptr;
        logic [LANE_W-1:0] w_grant;

        assign w_grant     = r_lock ? r_lock_lane : rr_pick(lane_out_valid_i, r_ret_ptr);
        assign w_ret_lane  = w_grant;
        assign w_ret_valid = (r_count != '0) & lane_out_valid_i[w_grant];

        always_comb begin
            w_lane_out_ready          = '0;
            w_lane_out_ready[w_grant] = w_ret_valid & out_ready_i & ~flush_i;
        end

        // Stalled grants are held so the presented result stays stable.
        always_ff @(posedge clk_i) begin
            if (!rst_ni || flush_i) begin
                r_lock      <= 1'b0;
                r_lock_lane <= '0;
                r_ret_ptr   <= '0;
            end else if (w_out_hs) begin
                r_lock    <= 1'b0;
                r_ret_ptr <= next_lane(w_grant);
            end else if (w_ret_valid && !out_ready_i) begin
                r_lock      <= 1'b1;
                r_lock_lane <= w_grant;
            end
        end
    end

    assign out_valid_o      = w_ret_valid;
    assign out_lane_o       = w_ret_lane;
    assign out_data_o       = lane_out_data_i[w_ret_lane];
    assign lane_out_ready_o = w_lane_out_ready;
    assign busy_o           = (|lane_busy_i) | (r_count != '0);

    a_dispatch_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(lane_valid_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_out_hs && (r_count == '0)));
    a_no_accept_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_accept && w_full));

endmodule

`default_nettype wire
